// File: rtl/uart_dma_mem_responder.sv
// Memory-side responder for the UART DMA TX-read and RX-write ports.
// Arbitrates between them and performs byte-lane accesses on a 1-cycle-latency SRAM.
module uart_dma_mem_responder #(
    parameter int         M_WIDTH    = 32,
    parameter int         ADDR_WIDTH = 12,
    parameter logic [1:0] MEM_ACC_8  = 2'b00,
    parameter logic [1:0] MEM_ACC_16 = 2'b01,
    parameter logic [1:0] MEM_ACC_32 = 2'b10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_mem_req,
    input  logic [M_WIDTH-1:0]    tx_mem_addr,
    input  logic [1:0]            tx_mem_width,
    output logic [M_WIDTH-1:0]    tx_mem_data_out,
    output logic                  tx_mem_ready,
    input  logic                  rx_mem_req,
    input  logic [M_WIDTH-1:0]    rx_mem_addr,
    input  logic [1:0]            rx_mem_width,
    input  logic [M_WIDTH-1:0]    rx_mem_data_in,
    output logic                  rx_mem_ready,
    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  access_err,
    input  logic                  err_clr
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_prio_rx;
    logic                  r_is_tx;
    logic                  r_illegal;
    logic [1:0]            r_off;
    logic [1:0]            r_width;
    logic                  r_mem_en;
    logic [3:0]            r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic                  r_tx_ready;
    logic                  r_rx_ready;
    logic [31:0]           r_tx_data;
    logic                  r_access_err;

    state_t                w_state_nxt;
    logic                  w_prio_rx_nxt;
    logic                  w_is_tx_nxt;
    logic                  w_illegal_nxt;
    logic [1:0]            w_off_nxt;
    logic [1:0]            w_width_nxt;
    logic                  w_mem_en_nxt;
    logic [3:0]            w_mem_we_nxt;
    logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
    logic [31:0]           w_mem_wdata_nxt;
    logic                  w_tx_ready_nxt;
    logic                  w_rx_ready_nxt;
    logic [31:0]           w_tx_data_nxt;
    logic                  w_access_err_nxt;

    logic                  w_tie;
    logic                  w_pick_tx;
    logic [ADDR_WIDTH-1:0] w_sel_waddr;
    logic [1:0]            w_sel_off;
    logic [1:0]            w_sel_width;
    logic                  w_sel_legal;
    logic                  w_unused;

    function automatic logic f_legal(input logic [1:0] width, input logic [1:0] off);
        case (width)
            MEM_ACC_8:  return 1'b1;
            MEM_ACC_16: return !off[0];
            MEM_ACC_32: return (off == 2'b00);
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] f_lane_we(input logic [1:0] width, input logic [1:0] off);
        case (width)
            MEM_ACC_8:  return 4'b0001 << off;
            MEM_ACC_16: return 4'b0011 << off;
            MEM_ACC_32: return 4'b1111;
            default:    return 4'b0000;
        endcase
    endfunction

    // Narrow writes are replicated across lanes; the byte enables pick the lane.
    function automatic logic [31:0] f_lane_wdata(input logic [1:0] width, input logic [31:0] d);
        case (width)
            MEM_ACC_8:  return {4{d[7:0]}};
            MEM_ACC_16: return {2{d[15:0]}};
            default:    return d;
        endcase
    endfunction

    function automatic logic [31:0] f_extract(input logic [1:0] width, input logic [1:0] off,
                                              input logic [31:0] rd);
        case (width)
            MEM_ACC_8: begin
                case (off)
                    2'd0:    return {24'h0, rd[7:0]};
                    2'd1:    return {24'h0, rd[15:8]};
                    2'd2:    return {24'h0, rd[23:16]};
                    default: return {24'h0, rd[31:24]};
                endcase
            end
            MEM_ACC_16: return off[1] ? {16'h0, rd[31:16]} : {16'h0, rd[15:0]};
            MEM_ACC_32: return rd;
            default:    return 32'h0;
        endcase
    endfunction

    // Ties alternate via r_prio_rx; a lone requester never moves the pointer.
    assign w_tie       = tx_mem_req & rx_mem_req;
    assign w_pick_tx   = tx_mem_req & (!rx_mem_req | !r_prio_rx);
    assign w_sel_waddr = w_pick_tx ? tx_mem_addr[ADDR_WIDTH+1:2] : rx_mem_addr[ADDR_WIDTH+1:2];
    assign w_sel_off   = w_pick_tx ? tx_mem_addr[1:0] : rx_mem_addr[1:0];
    assign w_sel_width = w_pick_tx ? tx_mem_width : rx_mem_width;
    assign w_sel_legal = f_legal(w_sel_width, w_sel_off);
    assign w_unused    = ^{tx_mem_addr[M_WIDTH-1:ADDR_WIDTH+2], rx_mem_addr[M_WIDTH-1:ADDR_WIDTH+2]};

    always_comb begin
        w_state_nxt      = r_state;
        w_prio_rx_nxt    = r_prio_rx;
        w_is_tx_nxt      = r_is_tx;
        w_illegal_nxt    = r_illegal;
        w_off_nxt        = r_off;
        w_width_nxt      = r_width;
        w_mem_en_nxt     = 1'b0;
        w_mem_we_nxt     = 4'b0000;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_wdata_nxt  = r_mem_wdata;
        w_tx_ready_nxt   = 1'b0;
        w_rx_ready_nxt   = 1'b0;
        w_tx_data_nxt    = r_tx_data;
        w_access_err_nxt = err_clr ? 1'b0 : r_access_err;

        case (r_state)
            S_IDLE: begin
                if (tx_mem_req || rx_mem_req) begin
                    w_state_nxt    = S_ISSUE;
                    w_is_tx_nxt    = w_pick_tx;
                    w_illegal_nxt  = !w_sel_legal;
                    w_off_nxt      = w_sel_off;
                    w_width_nxt    = w_sel_width;
                    w_mem_addr_nxt = w_sel_waddr;
                    if (w_tie) begin
                        w_prio_rx_nxt = w_pick_tx;
                    end
                    if (w_sel_legal) begin
                        w_mem_en_nxt = 1'b1;
                        if (!w_pick_tx) begin
                            w_mem_we_nxt    = f_lane_we(w_sel_width, w_sel_off);
                            w_mem_wdata_nxt = f_lane_wdata(w_sel_width, rx_mem_data_in);
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (r_is_tx && !r_illegal) begin
                    w_state_nxt = S_CAPTURE;
                end else begin
                    w_state_nxt = S_DONE;
                    if (r_is_tx) begin
                        w_tx_ready_nxt = 1'b1;
                        w_tx_data_nxt  = 32'h0;
                    end else begin
                        w_rx_ready_nxt = 1'b1;
                    end
                    if (r_illegal) begin
                        w_access_err_nxt = 1'b1;
                    end
                end
            end
            S_CAPTURE: begin
                w_state_nxt    = S_DONE;
                w_tx_ready_nxt = 1'b1;
                w_tx_data_nxt  = f_extract(r_width, r_off, mem_rdata);
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_prio_rx    <= 1'b1;
            r_is_tx      <= 1'b0;
            r_illegal    <= 1'b0;
            r_off        <= 2'b00;
            r_width      <= 2'b00;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 4'b0000;
            r_mem_addr   <= '0;
            r_mem_wdata  <= 32'h0;
            r_tx_ready   <= 1'b0;
            r_rx_ready   <= 1'b0;
            r_tx_data    <= 32'h0;
            r_access_err <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_prio_rx    <= w_prio_rx_nxt;
            r_is_tx      <= w_is_tx_nxt;
            r_illegal    <= w_illegal_nxt;
            r_off        <= w_off_nxt;
            r_width      <= w_width_nxt;
            r_mem_en     <= w_mem_en_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_tx_ready   <= w_tx_ready_nxt;
            r_rx_ready   <= w_rx_ready_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_access_err <= w_access_err_nxt;
        end
    end

    assign tx_mem_data_out = r_tx_data;
    assign tx_mem_ready    = r_tx_ready;
    assign rx_mem_ready    = r_rx_ready;
    assign mem_en          = r_mem_en;
    assign mem_we          = r_mem_we;
    assign mem_addr        = r_mem_addr;
    assign mem_wdata       = r_mem_wdata;
    assign access_err      = r_access_err;

endmodule

// File: tb/tb_uart_dma_mem_responder.sv
// Directed bench for uart_dma_mem_responder with a behavioural 1-cycle-latency SRAM.
module tb_uart_dma_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_mem_req;
    logic [31:0] tx_mem_addr;
    logic [1:0]  tx_mem_width;
    logic [31:0] tx_mem_data_out;
    logic        tx_mem_ready;
    logic        rx_mem_req;
    logic [31:0] rx_mem_addr;
    logic [1:0]  rx_mem_width;
    logic [31:0] rx_mem_data_in;
    logic        rx_mem_ready;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        access_err;
    logic        err_clr;

    logic [31:0] ram [0:4095] = '{default: 32'h0};

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_dma_mem_responder dut (
        .clk             (clk),
        .rst             (rst),
        .tx_mem_req      (tx_mem_req),
        .tx_mem_addr     (tx_mem_addr),
        .tx_mem_width    (tx_mem_width),
        .tx_mem_data_out (tx_mem_data_out),
        .tx_mem_ready    (tx_mem_ready),
        .rx_mem_req      (rx_mem_req),
        .rx_mem_addr     (rx_mem_addr),
        .rx_mem_width    (rx_mem_width),
        .rx_mem_data_in  (rx_mem_data_in),
        .rx_mem_ready    (rx_mem_ready),
        .mem_en          (mem_en),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .access_err      (access_err),
        .err_clr         (err_clr)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_we[i]) ram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [1:0] w,
                      input logic [31:0] d, input logic legal,
                      input logic [3:0] exp_we, input logic [31:0] exp_wd);
        rx_mem_req = 1'b1; rx_mem_addr = a; rx_mem_width = w; rx_mem_data_in = d;
        tick();
        chk({tag, "_en"}, {31'h0, mem_en}, {31'h0, legal});
        chk({tag, "_we"}, {28'h0, mem_we}, legal ? {28'h0, exp_we} : 32'h0);
        if (legal) begin
            chk({tag, "_addr"}, {20'h0, mem_addr}, {20'h0, a[13:2]});
            chk({tag, "_wdata"}, mem_wdata, exp_wd);
        end
        chk({tag, "_rdy_early"}, {31'h0, rx_mem_ready}, 32'h0);
        tick();
        chk({tag, "_rdy"}, {31'h0, rx_mem_ready}, 32'h1);
        chk({tag, "_en_off"}, {31'h0, mem_en}, 32'h0);
        rx_mem_req = 1'b0;
        tick();
        chk({tag, "_rdy_pulse"}, {31'h0, rx_mem_ready}, 32'h0);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [1:0] w,
                      input logic legal, input logic [31:0] exp_d);
        tx_mem_req = 1'b1; tx_mem_addr = a; tx_mem_width = w;
        tick();
        chk({tag, "_en"}, {31'h0, mem_en}, {31'h0, legal});
        chk({tag, "_we"}, {28'h0, mem_we}, 32'h0);
        if (legal) begin
            chk({tag, "_addr"}, {20'h0, mem_addr}, {20'h0, a[13:2]});
            tick();
            chk({tag, "_rdy_early"}, {31'h0, tx_mem_ready}, 32'h0);
        end
        tick();
        chk({tag, "_rdy"}, {31'h0, tx_mem_ready}, 32'h1);
        chk({tag, "_data"}, tx_mem_data_out, exp_d);
        tx_mem_req = 1'b0;
        tick();
        chk({tag, "_rdy_pulse"}, {31'h0, tx_mem_ready}, 32'h0);
        chk({tag, "_hold"}, tx_mem_data_out, exp_d);
    endtask

    initial begin
        rst = 1'b0;
        tx_mem_req = 1'b0; tx_mem_addr = 32'h0; tx_mem_width = 2'b00;
        rx_mem_req = 1'b0; rx_mem_addr = 32'h0; rx_mem_width = 2'b00; rx_mem_data_in = 32'h0;
        err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", {31'h0, mem_en}, 32'h0);
        chk("rst_we", {28'h0, mem_we}, 32'h0);
        chk("rst_addr", {20'h0, mem_addr}, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_txrdy", {31'h0, tx_mem_ready}, 32'h0);
        chk("rst_rxrdy", {31'h0, rx_mem_ready}, 32'h0);
        chk("rst_txdata", tx_mem_data_out, 32'h0);
        chk("rst_err", {31'h0, access_err}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Word write then read-back
        wr("t1_wr", 32'h10, 2'b10, 32'hDEADBEEF, 1'b1, 4'hF, 32'hDEADBEEF);
        rd("t1_rd", 32'h10, 2'b10, 1'b1, 32'hDEADBEEF);

        // Byte lanes
        wr("t2_b0", 32'h20, 2'b00, 32'h11, 1'b1, 4'h1, 32'h11111111);
        wr("t2_b1", 32'h21, 2'b00, 32'h22, 1'b1, 4'h2, 32'h22222222);
        wr("t2_b2", 32'h22, 2'b00, 32'h33, 1'b1, 4'h4, 32'h33333333);
        wr("t2_b3", 32'h23, 2'b00, 32'h44, 1'b1, 4'h8, 32'h44444444);
        rd("t2_rw", 32'h20, 2'b10, 1'b1, 32'h44332211);
        rd("t2_rh", 32'h22, 2'b01, 1'b1, 32'h00004433);
        rd("t2_rb", 32'h21, 2'b00, 1'b1, 32'h00000022);
        wr("t2_h", 32'h2A, 2'b01, 32'hBEEF, 1'b1, 4'hC, 32'hBEEFBEEF);
        rd("t2_rh2", 32'h28, 2'b10, 1'b1, 32'hBEEF0000);

        // Simultaneous requests: first tie to RX
        tx_mem_req = 1'b1; tx_mem_addr = 32'h10; tx_mem_width = 2'b10;
        rx_mem_req = 1'b1; rx_mem_addr = 32'h50; rx_mem_width = 2'b10; rx_mem_data_in = 32'hCAFEF00D;
        tick();
        chk("t3a_we", {28'h0, mem_we}, 32'hF);
        chk("t3a_addr", {20'h0, mem_addr}, 32'h14);
        tick();
        chk("t3a_rxrdy", {31'h0, rx_mem_ready}, 32'h1);
        chk("t3a_txrdy", {31'h0, tx_mem_ready}, 32'h0);
        rx_mem_req = 1'b0;
        tick();
        tick();
        chk("t3a_tx_en", {31'h0, mem_en}, 32'h1);
        chk("t3a_tx_we", {28'h0, mem_we}, 32'h0);
        chk("t3a_tx_addr", {20'h0, mem_addr}, 32'h4);
        tick();
        tick();
        chk("t3a_txrdy2", {31'h0, tx_mem_ready}, 32'h1);
        chk("t3a_txdata", tx_mem_data_out, 32'hDEADBEEF);
        tx_mem_req = 1'b0;
        tick();
        // Second tie goes to TX
        tx_mem_req = 1'b1; tx_mem_addr = 32'h50; tx_mem_width = 2'b10;
        rx_mem_req = 1'b1; rx_mem_addr = 32'h60; rx_mem_width = 2'b10; rx_mem_data_in = 32'h12345678;
        tick();
        chk("t3b_we", {28'h0, mem_we}, 32'h0);
        chk("t3b_addr", {20'h0, mem_addr}, 32'h14);
        tick();
        tick();
        chk("t3b_txrdy", {31'h0, tx_mem_ready}, 32'h1);
        chk("t3b_rxrdy", {31'h0, rx_mem_ready}, 32'h0);
        chk("t3b_txdata", tx_mem_data_out, 32'hCAFEF00D);
        tx_mem_req = 1'b0;
        tick();
        tick();
        chk("t3b_rx_we", {28'h0, mem_we}, 32'hF);
        chk("t3b_rx_addr", {20'h0, mem_addr}, 32'h18);
        tick();
        chk("t3b_rxrdy2", {31'h0, rx_mem_ready}, 32'h1);
        rx_mem_req = 1'b0;
        tick();
        rd("t3b_chk", 32'h60, 2'b10, 1'b1, 32'h12345678);

        // Illegal accesses and the sticky error flag
        chk("t4_err0", {31'h0, access_err}, 32'h0);
        rd("t4_rd", 32'h31, 2'b01, 1'b0, 32'h0);
        chk("t4_err_rd", {31'h0, access_err}, 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_clr", {31'h0, access_err}, 32'h0);
        wr("t4_wr", 32'h42, 2'b10, 32'hFFFFFFFF, 1'b0, 4'h0, 32'h0);
        chk("t4_err_wr", {31'h0, access_err}, 32'h1);
        rd("t4_nowrite", 32'h40, 2'b10, 1'b1, 32'h0);
        err_clr = 1'b1;
        tick();
        chk("t4_clr2", {31'h0, access_err}, 32'h0);
        tx_mem_req = 1'b1; tx_mem_addr = 32'h0; tx_mem_width = 2'b11;
        tick();
        chk("t4_w3_en", {31'h0, mem_en}, 32'h0);
        chk("t4_w3_err_pre", {31'h0, access_err}, 32'h0);
        tick();
        chk("t4_w3_rdy", {31'h0, tx_mem_ready}, 32'h1);
        chk("t4_w3_setwins", {31'h0, access_err}, 32'h1);
        tx_mem_req = 1'b0;
        err_clr = 1'b0;
        tick();
        chk("t4_w3_sticky", {31'h0, access_err}, 32'h1);

        // Asynchronous reset during a write issue
        rx_mem_req = 1'b1; rx_mem_addr = 32'h70; rx_mem_width = 2'b10; rx_mem_data_in = 32'h55AA55AA;
        tick();
        chk("t5_en_pre", {31'h0, mem_en}, 32'h1);
        #3;
        rst = 1'b0;
        #1;
        chk("t5_en_async", {31'h0, mem_en}, 32'h0);
        chk("t5_we_async", {28'h0, mem_we}, 32'h0);
        chk("t5_err_async", {31'h0, access_err}, 32'h0);
        rx_mem_req = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_rdy_none", {31'h0, rx_mem_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("t5_idle_rdy", {31'h0, rx_mem_ready}, 32'h0);
        chk("t5_idle_en", {31'h0, mem_en}, 32'h0);
        rd("t5_aborted", 32'h70, 2'b10, 1'b1, 32'h0);
        wr("t5_wr", 32'h70, 2'b10, 32'h13579BDF, 1'b1, 4'hF, 32'h13579BDF);
        rd("t5_rd", 32'h70, 2'b10, 1'b1, 32'h13579BDF);

        // Address bits above the RAM size wrap
        wr("t6_wrap", 32'h4010, 2'b10, 32'h0BADF00D, 1'b1, 4'hF, 32'h0BADF00D);
        rd("t6_rd", 32'h10, 2'b10, 1'b1, 32'h0BADF00D);
        rd("t6_rb3", 32'h13, 2'b00, 1'b1, 32'h0000000B);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_dma_mem_responder.md
Name: uart_dma_mem_responder

Overview:
Memory-side responder for the two UART DMA initiator ports: the TX read port and the RX write port. It arbitrates between them and performs 8/16/32-bit byte-lane accesses on a single-port, word-addressed synchronous SRAM with 1-cycle read latency. It returns a one-cycle ready pulse per completed request. It sits between the UART DMA ports and the on-chip data RAM.

Parameters:
M_WIDTH, 32, data/address width of the initiator ports; only 32 is supported.
ADDR_WIDTH, 12, SRAM word-address width; the byte address is used as bits [ADDR_WIDTH+1:2].
MEM_ACC_8, 2'b00, width code for a byte access.
MEM_ACC_16, 2'b01, width code for a halfword access.
MEM_ACC_32, 2'b10, width code for a word access.

Ports:
clk  in  1  single clock; all logic on the rising edge.
rst  in  1  asynchronous, active-low reset.
tx_mem_req  in  1  TX read request; held with addr/width stable until tx_mem_ready.
tx_mem_addr  in  M_WIDTH  TX byte address.
tx_mem_width  in  2  TX access width code.
tx_mem_data_out  out  M_WIDTH  read data, right-justified and zero-extended; valid while tx_mem_ready=1.
tx_mem_ready  out  1  one-cycle completion pulse for a TX request.
rx_mem_req  in  1  RX write request; held with addr/width/data stable until rx_mem_ready.
rx_mem_addr  in  M_WIDTH  RX byte address.
rx_mem_width  in  2  RX access width code.
rx_mem_data_in  in  M_WIDTH  write data, right-justified.
rx_mem_ready  out  1  one-cycle completion pulse for an RX request.
mem_en  out  1  SRAM access strobe.
mem_we  out  4  SRAM byte write enables; all zero for a read.
mem_addr  out  ADDR_WIDTH  SRAM word address.
mem_wdata  out  32  SRAM write data, lane-positioned.
mem_rdata  in  32  SRAM read data; valid in the cycle after mem_en for a read.
access_err  out  1  sticky flag for a misaligned or illegal-width access.
err_clr  in  1  synchronous clear of access_err.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. The following outputs are 0: mem_en, mem_we, mem_addr, mem_wdata, tx_mem_ready, rx_mem_ready, tx_mem_data_out, access_err. The arbitration pointer is set to favour RX.
- A reset mid-access aborts the access immediately: mem_en/mem_we drop asynchronously and no ready pulse is issued.
- All outputs are registered.
- FSM states:
  - IDLE -> ISSUE when any req is high.
  - ISSUE -> DONE for a write or a rejected access.
  - ISSUE -> CAPTURE for a legal read.
  - CAPTURE -> DONE.
  - DONE -> IDLE.
- Timing, with the request sampled in IDLE at the end of cycle N:
  - Cycle N+1 (ISSUE): mem_en=1, mem_addr, mem_we and mem_wdata driven.
  - Write: rx_mem_ready=1 in cycle N+2.
  - Read: mem_rdata is captured in cycle N+2; tx_mem_ready=1 with data in cycle N+3.
- Ready is high for exactly one cycle.
- The requester must deassert req in the cycle after ready. The block samples req again only in the following IDLE cycle, so the minimum spacing is 3 cycles per write and 4 cycles per read.
- Arbitration:
  - Both ports requesting in IDLE: round-robin. The port not granted last wins; the first tie after reset goes to RX.
  - A single requester is always granted.
  - The losing port's req stays pending and is served next.
- Lane mapping (off = addr[1:0]):
  - 8-bit: mem_we = 1<<off; wdata byte 0 is replicated to all lanes; read data = rdata byte[off], zero-extended.
  - 16-bit: legal only when off[0]=0. mem_we = 2'b11<<off; read data = rdata[16*off[1] +: 16], zero-extended.
  - 32-bit: legal only when off=0. mem_we = 4'hF.
- Illegal access (misaligned, or width 2'b11):
  - mem_en stays 0 in ISSUE; no SRAM access occurs.
  - The FSM goes to DONE and the ready pulse is still issued; read data = 0.
  - access_err is set at the same edge as the ready pulse.
- access_err: err_clr clears it. If err_clr and a new error occur in the same cycle, the set wins.
- Address bits above ADDR_WIDTH+1 are ignored (the address wraps modulo the RAM size).
- tx_mem_data_out holds its last value outside its ready cycle.

Test Plan:
1. RX write 32'hDEADBEEF, width 32, addr 0x10 -> mem_en=1, mem_we=4'hF, mem_addr=4 in N+1; rx_mem_ready=1 in N+2 only. A subsequent TX read of 0x10 returns 32'hDEADBEEF with tx_mem_ready in N+3.
2. Byte writes 0x11, 0x22, 0x33, 0x44 to 0x20..0x23 -> mem_we = 1, 2, 4, 8 respectively. A 32-bit read of 0x20 returns 32'h44332211; a 16-bit read of 0x22 returns 32'h00004433; an 8-bit read of 0x21 returns 32'h00000022.
3. TX and RX both request in the same IDLE cycle, first time after reset -> RX is served first, then TX. A second simultaneous pair is served TX first. No request is dropped.
4. 16-bit read at 0x31 and 32-bit write at 0x42 -> no mem_en, ready still pulses, read data=0, access_err=1. err_clr=1 clears it the next cycle.
5. rst asserted during ISSUE of a write -> mem_en/mem_we go to 0 without waiting for a clock edge, no ready pulse, FSM in IDLE. After release, a new request completes with normal latency.
